// File: rtl/cmos_byte_pair_packer_pkg.sv
// rtl/cmos_byte_pair_packer_pkg.sv - shared camera channel constants
//
// Purpose: byte width, RGB565 field positions and byte packing order shared
// by the camera input path (packer, RGB565 reorder, frame buffer).
package cmos_byte_pair_packer_pkg;

    // Sensor DVP byte width; a packed word is two of these.
    localparam int CAM_DATA_W = 8;
    localparam int CAM_WORD_W = 2 * CAM_DATA_W;

    // RGB565 field positions within a packed word.
    localparam int RGB565_R_MSB = 15;
    localparam int RGB565_R_LSB = 11;
    localparam int RGB565_G_MSB = 10;
    localparam int RGB565_G_LSB = 5;
    localparam int RGB565_B_MSB = 4;
    localparam int RGB565_B_LSB = 0;

    // Packing order: 1 puts the first byte of a pair in the upper half.
    localparam bit CAM_MSB_FIRST = 1'b1;

endpackage

// File: rtl/cmos_byte_pair_packer.sv
// rtl/cmos_byte_pair_packer.sv - DVP byte stream to 16-bit word packer
//
// Purpose: pairs consecutive sensor bytes into one word, holds each word with
// a two-cycle valid window, and emits a pclk/2 strobe whose rising edge sits
// in the middle of that window. Runs entirely on the sensor pixel clock.
//
// Ports:
//   pclk       in   sensor pixel clock
//   rst        in   synchronous active-high reset
//   pdata_i    in   registered sensor byte
//   de_i       in   registered href (byte valid)
//   vs_i       in   registered vsync, high during frame blanking
//   pixel_clk  out  pclk/2 word strobe, 0 then 1 across each word window
//   pdata_o    out  packed word
//   de_o       out  word valid
//   vs_o       out  vs_i delayed one pclk
module cmos_byte_pair_packer
    import cmos_byte_pair_packer_pkg::*;
#(
    parameter int DATA_W    = CAM_DATA_W,
    parameter bit MSB_FIRST = CAM_MSB_FIRST
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     pdata_i,
    input  logic                  de_i,
    input  logic                  vs_i,
    output logic                  pixel_clk,
    output logic [2*DATA_W-1:0]   pdata_o,
    output logic                  de_o,
    output logic                  vs_o
);

    logic                ph_q, ph_d;
    logic                hold_q, hold_d;
    logic [DATA_W-1:0]   byte_q, byte_d;
    logic [2*DATA_W-1:0] word_q, word_d;
    logic                de_q, de_d;
    logic                strobe_q, strobe_d;
    logic                vs_q;

    logic                active;
    logic                complete;

    // Bytes only count while href is high outside vertical blanking.
    assign active   = de_i & ~vs_i;
    assign complete = active & ph_q;

    always_comb begin
        ph_d     = active ? ~ph_q : 1'b0;
        hold_d   = 1'b0;
        byte_d   = byte_q;
        word_d   = word_q;
        de_d     = 1'b0;
        strobe_d = ~strobe_q;

        if (active && !ph_q) begin
            byte_d = pdata_i;
        end

        if (complete) begin
            word_d   = MSB_FIRST ? {byte_q, pdata_i} : {pdata_i, byte_q};
            de_d     = 1'b1;
            hold_d   = 1'b1;
            // Forcing the strobe low here puts its rising edge mid-window.
            strobe_d = 1'b0;
        end else if (!vs_i && hold_q) begin
            // Second cycle of the window: keep valid, drop hold so the
            // window closes on the next edge unless another word lands.
            de_d = 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            ph_q     <= 1'b0;
            hold_q   <= 1'b0;
            byte_q   <= '0;
            word_q   <= '0;
            de_q     <= 1'b0;
            strobe_q <= 1'b0;
            vs_q     <= 1'b0;
        end else begin
            ph_q     <= ph_d;
            hold_q   <= hold_d;
            byte_q   <= byte_d;
            word_q   <= word_d;
            de_q     <= de_d;
            strobe_q <= strobe_d;
            vs_q     <= vs_i;
        end
    end

    assign pixel_clk = strobe_q;
    assign pdata_o   = word_q;
    assign de_o      = de_q;
    assign vs_o      = vs_q;

endmodule

// File: tb/tb_cmos_byte_pair_packer.sv
// tb/tb_cmos_byte_pair_packer.sv - directed bench for the byte pair packer
module tb_cmos_byte_pair_packer;

    logic        pclk;
    logic        rst;
    logic [7:0]  pdata_i;
    logic        de_i;
    logic        vs_i;

    logic        pixel_clk, pixel_clk_l;
    logic [15:0] pdata_o, pdata_o_l;
    logic        de_o, de_o_l;
    logic        vs_o, vs_o_l;

    int tests_run    = 0;
    int tests_failed = 0;

    cmos_byte_pair_packer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_dut (
        .pclk      (pclk),
        .rst       (rst),
        .pdata_i   (pdata_i),
        .de_i      (de_i),
        .vs_i      (vs_i),
        .pixel_clk (pixel_clk),
        .pdata_o   (pdata_o),
        .de_o      (de_o),
        .vs_o      (vs_o)
    );

    cmos_byte_pair_packer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_dut_lsb (
        .pclk      (pclk),
        .rst       (rst),
        .pdata_i   (pdata_i),
        .de_i      (de_i),
        .vs_i      (vs_i),
        .pixel_clk (pixel_clk_l),
        .pdata_o   (pdata_o_l),
        .de_o      (de_o_l),
        .vs_o      (vs_o_l)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present inputs, let one edge sample them, then settle 1 ns past it.
    task automatic cycle(input logic de, input logic vs, input logic [7:0] d);
        de_i    = de;
        vs_i    = vs;
        pdata_i = d;
        @(posedge pclk);
        #1;
    endtask

    initial begin
        rst = 1'b1; de_i = 1'b0; vs_i = 1'b0; pdata_i = 8'h00;

        // Reset with de_i toggling: every output stays 0.
        for (int i = 0; i < 3; i++) begin
            cycle(i[0], 1'b0, 8'h5A);
            check("rst_pdata", pdata_o, 16'h0000);
            check("rst_de", de_o, 1'b0);
            check("rst_pix", pixel_clk, 1'b0);
            check("rst_vs", vs_o, 1'b0);
        end
        rst = 1'b0;

        // Strobe free-runs 1,0,1 from the first cycle after release.
        cycle(1'b0, 1'b0, 8'h00); check("idle_pix0", pixel_clk, 1'b1);
        cycle(1'b0, 1'b0, 8'h00); check("idle_pix1", pixel_clk, 1'b0);
        cycle(1'b0, 1'b0, 8'h00); check("idle_pix2", pixel_clk, 1'b1);

        // Single pair.
        cycle(1'b1, 1'b0, 8'hAB); check("pair_de_lat", de_o, 1'b0);
        cycle(1'b1, 1'b0, 8'hCD);
        check("pair_data", pdata_o, 16'hABCD);
        check("pair_de0", de_o, 1'b1);
        check("pair_pix0", pixel_clk, 1'b0);
        cycle(1'b0, 1'b0, 8'h00);
        check("pair_de1", de_o, 1'b1);
        check("pair_pix1", pixel_clk, 1'b1);
        check("pair_hold", pdata_o, 16'hABCD);
        cycle(1'b0, 1'b0, 8'h00);
        check("pair_de_end", de_o, 1'b0);
        check("pair_keep", pdata_o, 16'hABCD);

        // Burst 0x01..0x08: words 0x0102..0x0708, de_o high 8 cycles.
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 1'b0, k[7:0]);
            if (k == 1) begin
                check("burst_de_first", de_o, 1'b0);
            end else begin
                check("burst_de", de_o, 1'b1);
                check("burst_data", pdata_o,
                      {16'h0, 8'(2*(k/2)-1), 8'(2*(k/2))});
                check("burst_pix", pixel_clk, k[0]);
            end
            if (k == 2) check("burst_lsb_first", pdata_o_l, 16'h0201);
        end
        cycle(1'b0, 1'b0, 8'h00);
        check("burst_de_tail", de_o, 1'b1);
        check("burst_last", pdata_o, 16'h0708);
        cycle(1'b0, 1'b0, 8'h00);
        check("burst_de_off", de_o, 1'b0);

        // Odd line: trailing 0x33 must be dropped, next line starts even.
        cycle(1'b1, 1'b0, 8'h11);
        cycle(1'b1, 1'b0, 8'h22); check("odd_w0", pdata_o, 16'h1122);
        cycle(1'b1, 1'b0, 8'h33); check("odd_w0_hold", pdata_o, 16'h1122);
        cycle(1'b0, 1'b0, 8'h00);
        check("odd_de_off", de_o, 1'b0);
        check("odd_no33", pdata_o, 16'h1122);
        cycle(1'b1, 1'b0, 8'h44);
        check("odd_no3344", pdata_o, 16'h1122);
        check("odd_de_wait", de_o, 1'b0);
        cycle(1'b1, 1'b0, 8'h55);
        check("odd_w1", pdata_o, 16'h4455);
        check("odd_w1_de", de_o, 1'b1);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        // Vsync rises one cycle after the first byte of a pair.
        cycle(1'b1, 1'b0, 8'h66); check("vs_pre", vs_o, 1'b0);
        cycle(1'b1, 1'b1, 8'h77);
        check("vs_abort_de", de_o, 1'b0);
        check("vs_abort_data", pdata_o, 16'h4455);
        check("vs_follow", vs_o, 1'b1);
        cycle(1'b0, 1'b1, 8'h00);
        check("vs_de_blank", de_o, 1'b0);
        cycle(1'b1, 1'b0, 8'h88);
        check("vs_fall", vs_o, 1'b0);
        check("vs_no_word", de_o, 1'b0);
        cycle(1'b1, 1'b0, 8'h99);
        check("vs_after_word", pdata_o, 16'h8899);

        // Reset in the middle of a window.
        cycle(1'b1, 1'b0, 8'hA1);
        cycle(1'b1, 1'b0, 8'hB2);
        check("mid_de", de_o, 1'b1);
        check("mid_data", pdata_o, 16'hA1B2);
        rst = 1'b1;
        cycle(1'b1, 1'b0, 8'hEE);
        check("mid_rst_de", de_o, 1'b0);
        check("mid_rst_data", pdata_o, 16'h0000);
        check("mid_rst_pix", pixel_clk, 1'b0);
        rst = 1'b0;
        cycle(1'b1, 1'b0, 8'hC3);
        check("restart_wait", de_o, 1'b0);
        cycle(1'b1, 1'b0, 8'hD4);
        check("restart_data", pdata_o, 16'hC3D4);
        check("restart_lsb", pdata_o_l, 16'hD4C3);
        cycle(1'b0, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cmos_byte_pair_packer.md
Name: cmos_byte_pair_packer

Overview:
- Converts the 8-bit DVP byte stream of an OV5640-class sensor (two bytes per RGB565 pixel) into 16-bit words.
- Also produces a half-rate pixel strobe aligned to the words, plus realigned valid and vsync signals.
- Sits directly after the input register stage of each camera channel, ahead of the RGB565 reorder and frame buffer logic.
- Whole block runs on the sensor pixel clock.

Parameters:
- DATA_W, 8, input byte width; output word is 2*DATA_W.
- MSB_FIRST, 1, when 1 the first byte of a pair is the upper half of pdata_o; when 0 it is the lower half.

Ports:
- pclk  input  1  sensor pixel clock; only clock.
- rst  input  1  synchronous, active-high reset. Tied to the inverse of the channel's register-config-done flag.
- pdata_i  input  DATA_W  registered sensor byte.
- de_i  input  1  registered href (byte valid).
- vs_i  input  1  registered vsync; high = frame blanking.
- pixel_clk  output  1  pclk/2 word strobe; its rising edge falls mid-way through each word's valid window.
- pdata_o  output  2*DATA_W  packed word.
- de_o  output  1  word valid.
- vs_o  output  1  vs_i delayed one pclk.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset state: pdata_o=0, de_o=0, pixel_clk=0, vs_o=0, internal phase ph=0, hold=0, byte register=0.
- Phase tracking:
  - If de_i=1 and vs_i=0, then ph<=~ph.
  - Otherwise ph<=0, so every line starts on an even byte.
- First byte: with de_i=1 and ph=0, capture pdata_i into the byte register.
- Word completion, with de_i=1 and ph=1, on the next edge:
  - pdata_o <= {byte_reg,pdata_i} if MSB_FIRST, else {pdata_i,byte_reg}.
  - de_o<=1, hold<=1, pixel_clk<=0.
- Latency: pdata_o and de_o are visible 2 cycles after the first byte of the pair is presented.
- Valid window:
  - de_o stays 1 for exactly 2 pclk cycles per word; pdata_o is stable for that window.
  - pdata_o holds its last value until the next word.
  - In the cycle after the completion edge, if no new completion occurs: hold<=0. de_o<=0 on the following edge unless another word completes.
  - A continuous de_i burst therefore gives a continuous de_o with pdata_o changing every 2 cycles.
- pixel_clk:
  - Toggles every cycle, except it is forced to 0 on a completion edge.
  - It is therefore 1 in the second cycle of each word window.
  - It free-runs at pclk/2 while idle.
- Odd byte count: if de_i falls while ph=1, the pending byte is discarded. No word is produced; ph returns to 0.
- vs_i=1:
  - ph<=0, de_o<=0, hold<=0 on the next edge, aborting any pending pair or active window.
  - pdata_o keeps its value; pixel_clk keeps toggling.
- vs_o <= vs_i every cycle, with no gating.
- Reset mid-line: all state clears on that edge. Packing restarts at the first de_i byte after rst deasserts.
- No back-pressure; input bytes are never stalled.

Decomposition:
- Shared camera package: DATA_W default (8), the RGB565 field positions, and the packing-order constants (MSB_FIRST=1).
- No sub-module; phase, hold and strobe logic are a few registers and fit in one module.

Test Plan:
- Reset: assert rst 3 cycles with de_i toggling -> all outputs 0. After release, pixel_clk toggles 1,0,1... from the first cycle.
- Single pair: de_i=1 for 2 cycles carrying 0xAB, 0xCD (MSB_FIRST=1) -> pdata_o=0xABCD and de_o=1 for exactly 2 cycles starting 2 cycles after 0xAB. pixel_clk is 0 then 1 in that window.
- Burst: 8 bytes 0x01..0x08 -> words 0x0102, 0x0304, 0x0506, 0x0708, each held 2 cycles, de_o continuously 1 for 8 cycles. With MSB_FIRST=0 the first word is 0x0201.
- Odd line: 3 bytes 0x11, 0x22, 0x33 then de_i=0, then a new line 0x44, 0x55 -> only 0x1122 and 0x4455 appear; 0x33 never appears.
- vsync abort: vs_i rises one cycle after the first byte of a pair -> no word; de_o=0; vs_o follows vs_i one cycle later.
- Reset mid-window: rst during de_o=1 -> de_o and pdata_o are 0 on the next cycle.
